mcb_ref_sched: RTL
==================

Name: mcb_ref_sched

Overview:
Multi-rank refresh scheduler for the sdrc_lite MCB back-end. It is the parametrised successor to the single-rank refresh request/alert logic. Each rank keeps its own tREFI interval counter, and the counters are staggered so ranks do not refresh together. Each rank also keeps a signed refresh-debt count, which lets refreshes be postponed (up to MAX_POSTPONE) or pulled in early while the controller is idle (up to MAX_PULLIN). The block presents one arbitrated refresh request to the command sequencer.

Parameters:
RANKS, 2, number of ranks (power of 2, 1..8)
RANK_W, 1, rank index width (log2 RANKS, minimum 1)
CTREFI, 1560, refresh interval in mcb_clk cycles
CNT_W, 11, interval counter width; 2^CNT_W > CTREFI
MAX_POSTPONE, 8, maximum owed refreshes per rank
MAX_PULLIN, 8, maximum refreshes issued ahead per rank
DEBT_W, 5, signed debt width; must hold -MAX_PULLIN..MAX_POSTPONE

Ports:
mcb_clk  in  1  clock
mcb_rst  in  1  reset; synchronous, active-high
mcb_sclr_n  in  1  synchronous soft clear, active-low
i_ready  in  1  SDRAM init complete
c_idle  in  1  controller has no pending traffic; enables pull-in
c_ref_ack  in  1  one-cycle pulse: a refresh command was issued
c_ref_rank  in  RANK_W  rank refreshed by c_ref_ack
r_ref_req  out  1  refresh request (registered)
r_ref_rank  out  RANK_W  rank for r_ref_req (registered)
r_ref_urgent  out  1  requested rank is at MAX_POSTPONE; controller must refresh before new activates
r_ref_err  out  1  sticky error flag

Behaviour:
- Reset and clear:
  - mcb_rst=1 or mcb_sclr_n=0 at a clock edge: all outputs go to 0, every debt goes to 0, and every cnt[r] is loaded with r*(CTREFI/RANKS).
  - mcb_rst takes precedence. Reset is honoured at any time, including mid-request.
- Before initialisation: while i_ready=0, counters hold their stagger values, debts stay 0, and r_ref_req, r_ref_urgent and r_ref_rank stay 0. c_ref_ack is ignored. r_ref_err is held (only reset/clear clears it).
- Interval counters: each cycle with i_ready=1, cnt[r] increments. When cnt[r]==CTREFI-1 it wraps to 0 and raises an internal tick[r] for that cycle.
- Debt update, per rank, per cycle:
  - tick only: debt+1. If debt is already MAX_POSTPONE, it saturates and r_ref_err is set.
  - ack only (c_ref_ack=1 and c_ref_rank==r): debt-1. If debt is already -MAX_PULLIN, the ack is ignored and r_ref_err is set.
  - tick and ack on the same rank in the same cycle: debt unchanged, no error.
  - A debt change is visible to the arbiter on the next cycle.
- Eligibility and priority classes:
  - U (urgent): debt==MAX_POSTPONE.
  - N (normal): 0<debt<MAX_POSTPONE.
  - P (pull-in): c_idle=1 and -MAX_PULLIN<debt<=0.
  - Priority is U > N > P.
- Arbitration: within a class, round-robin starting from rr_ptr+1 (mod RANKS). rr_ptr updates to c_ref_rank on every accepted ack and resets to RANKS-1.
- Outputs:
  - Registered from the current debts and c_idle, giving one-cycle latency.
  - The cycle after an accepted ack, r_ref_req is forced to 0 (a one-cycle bubble). It is then re-evaluated against the updated debts.
  - r_ref_urgent=1 only when r_ref_req=1 and the selected rank is in class U.
  - r_ref_rank holds its last value while r_ref_req=0.
- Handshake:
  - The request stays asserted until acked or until it becomes ineligible. For example, when c_idle drops, a P-class request deasserts on the next cycle.
  - An ack for a rank other than r_ref_rank is accepted against that rank's debt under the same rules.
- Arithmetic: debts are two's-complement DEBT_W; the counters are unsigned and never exceed CTREFI-1.

Test Plan:
1. RANKS=2, CTREFI=16; release mcb_rst, i_ready=1, c_idle=0 -> rank1 ticks after 8 cycles, and r_ref_req=1 with r_ref_rank=1 appears 2 cycles after its tick. Rank0 ticks at cycle 16.
2. No acks for 8 rank0 ticks -> rank0 debt 8, r_ref_req=1, r_ref_rank=0, r_ref_urgent=1. On the 9th tick -> r_ref_err=1 and the debt stays 8. r_ref_err persists until mcb_sclr_n=0.
3. c_idle=1, rank0 debt 0, ack rank0 8 times -> debt -8. The request bubbles one cycle after each ack, and after the 8th ack rank0 is no longer requested. A 9th ack to rank0 -> r_ref_err=1.
4. Force a rank0 ack in the same cycle as rank0's tick, debt 3 -> debt remains 3 and no error.
5. Both ranks at debt 2, ack each granted request -> grants alternate 0,1,0,1 with a one-cycle bubble after each ack. A rank reaching MAX_POSTPONE preempts the other rank's N-class request.
6. Assert mcb_rst while r_ref_req=1 and debts are nonzero -> next cycle all outputs 0, debts 0, and counters reloaded to 0 and 8.

Source files
------------

// File: rtl/mcb_ref_sched.sv
// mcb_ref_sched: multi-rank refresh scheduler for the sdrc_lite MCB back-end.
// Each rank runs its own tREFI interval counter (staggered so ranks do not
// refresh together) and a signed refresh-debt count. Positive debt means
// refreshes are owed (postponed); negative debt means refreshes were pulled
// in early while the controller was idle. One arbitrated request is
// presented to the command sequencer.
//
// Ports:
//   mcb_clk      in   clock
//   mcb_rst      in   synchronous active-high reset (wins over soft clear)
//   mcb_sclr_n   in   synchronous soft clear, active-low
//   i_ready      in   SDRAM init complete; nothing advances until set
//   c_idle       in   controller has no pending traffic; enables pull-in
//   c_ref_ack    in   one-cycle pulse: refresh issued to c_ref_rank
//   c_ref_rank   in   rank refreshed by c_ref_ack
//   r_ref_req    out  registered refresh request
//   r_ref_rank   out  rank for r_ref_req (holds while r_ref_req=0)
//   r_ref_urgent out  requested rank is at MAX_POSTPONE
//   r_ref_err    out  sticky error: debt overflow or pull-in overrun
module mcb_ref_sched #(
  parameter int RANKS        = 2,
  parameter int RANK_W       = 1,
  parameter int CTREFI       = 1560,
  parameter int CNT_W        = 11,
  parameter int MAX_POSTPONE = 8,
  parameter int MAX_PULLIN   = 8,
  parameter int DEBT_W       = 5
) (
  input  logic              mcb_clk,
  input  logic              mcb_rst,
  input  logic              mcb_sclr_n,
  input  logic              i_ready,
  input  logic              c_idle,
  input  logic              c_ref_ack,
  input  logic [RANK_W-1:0] c_ref_rank,
  output logic              r_ref_req,
  output logic [RANK_W-1:0] r_ref_rank,
  output logic              r_ref_urgent,
  output logic              r_ref_err
);

  localparam logic signed [DEBT_W-1:0] DEBT_HI   = DEBT_W'(MAX_POSTPONE);
  localparam logic signed [DEBT_W-1:0] DEBT_LO   = DEBT_W'(-MAX_PULLIN);
  localparam logic signed [DEBT_W-1:0] DEBT_ZERO = '0;
  localparam logic signed [DEBT_W-1:0] DEBT_ONE  = DEBT_W'(1);
  localparam logic [CNT_W-1:0]         CNT_LAST  = CNT_W'(CTREFI - 1);

  logic [CNT_W-1:0]         cnt  [RANKS];
  logic signed [DEBT_W-1:0] debt [RANKS];
  logic [RANK_W-1:0]        rr_ptr;

  logic              clr;
  logic [RANKS-1:0]  tick;
  logic [RANKS-1:0]  ack_hit;
  logic [RANKS-1:0]  is_u;
  logic [RANKS-1:0]  is_n;
  logic [RANKS-1:0]  is_p;
  logic              ack_ok;
  logic              err_set;

  logic              u_hit, n_hit, p_hit;
  logic [RANK_W-1:0] u_sel, n_sel, p_sel;
  logic              vld_p0;
  logic [RANK_W-1:0] rank_p0;
  logic              urgent_p0;

  // Saturating debt step: tick adds one, ack removes one, both cancel.
  function automatic logic signed [DEBT_W-1:0] debt_next(
    input logic signed [DEBT_W-1:0] d,
    input logic                     t,
    input logic                     a
  );
    debt_next = d;
    if (t && !a && d != DEBT_HI)
      debt_next = d + DEBT_ONE;
    else if (a && !t && d != DEBT_LO)
      debt_next = d - DEBT_ONE;
  endfunction

  // A step that would leave the legal debt range is dropped and flagged.
  function automatic logic debt_fault(
    input logic signed [DEBT_W-1:0] d,
    input logic                     t,
    input logic                     a
  );
    debt_fault = (t && !a && d == DEBT_HI) || (a && !t && d == DEBT_LO);
  endfunction

  assign clr = mcb_rst || !mcb_sclr_n;

  always_comb begin
    ack_ok  = 1'b0;
    err_set = 1'b0;
    for (int r = 0; r < RANKS; r++) begin
      tick[r]    = i_ready && (cnt[r] == CNT_LAST);
      ack_hit[r] = i_ready && c_ref_ack && (c_ref_rank == RANK_W'(r));
      is_u[r]    = (debt[r] == DEBT_HI);
      is_n[r]    = (debt[r] > DEBT_ZERO) && (debt[r] < DEBT_HI);
      is_p[r]    = c_idle && (debt[r] > DEBT_LO) && (debt[r] <= DEBT_ZERO);
      if (ack_hit[r] && !debt_fault(debt[r], tick[r], 1'b1))
        ack_ok = 1'b1;
      if (debt_fault(debt[r], tick[r], ack_hit[r]))
        err_set = 1'b1;
    end
  end

  // Stage p0: round-robin pick per class, searching from rr_ptr+1. The scan
  // runs from the farthest offset down so the nearest hit is written last.
  always_comb begin
    u_hit = 1'b0;
    n_hit = 1'b0;
    p_hit = 1'b0;
    u_sel = '0;
    n_sel = '0;
    p_sel = '0;
    for (int k = RANKS; k >= 1; k--) begin
      for (int r = 0; r < RANKS; r++) begin
        if (r == (int'(rr_ptr) + k) % RANKS) begin
          if (is_u[r]) begin
            u_hit = 1'b1;
            u_sel = RANK_W'(r);
          end
          if (is_n[r]) begin
            n_hit = 1'b1;
            n_sel = RANK_W'(r);
          end
          if (is_p[r]) begin
            p_hit = 1'b1;
            p_sel = RANK_W'(r);
          end
        end
      end
    end
    vld_p0    = u_hit || n_hit || p_hit;
    urgent_p0 = u_hit;
    if (u_hit)
      rank_p0 = u_sel;
    else if (n_hit)
      rank_p0 = n_sel;
    else
      rank_p0 = p_sel;
  end

  always_ff @(posedge mcb_clk) begin
    if (clr) begin
      for (int r = 0; r < RANKS; r++) begin
        cnt[r]  <= CNT_W'(r * (CTREFI / RANKS));
        debt[r] <= DEBT_ZERO;
      end
      rr_ptr <= RANK_W'(RANKS - 1);
    end else if (i_ready) begin
      for (int r = 0; r < RANKS; r++) begin
        cnt[r]  <= tick[r] ? '0 : cnt[r] + 1'b1;
        debt[r] <= debt_next(debt[r], tick[r], ack_hit[r]);
      end
      if (ack_ok)
        rr_ptr <= c_ref_rank;
    end
  end

  // Stage p1: registered outputs. An accepted ack forces a one-cycle bubble
  // because the arbiter still sees the pre-ack debt on that cycle.
  always_ff @(posedge mcb_clk) begin
    if (clr) begin
      r_ref_req    <= 1'b0;
      r_ref_rank   <= '0;
      r_ref_urgent <= 1'b0;
      r_ref_err    <= 1'b0;
    end else if (!i_ready) begin
      r_ref_req    <= 1'b0;
      r_ref_rank   <= '0;
      r_ref_urgent <= 1'b0;
    end else begin
      r_ref_err <= r_ref_err || err_set;
      if (ack_ok) begin
        r_ref_req    <= 1'b0;
        r_ref_urgent <= 1'b0;
      end else begin
        r_ref_req    <= vld_p0;
        r_ref_urgent <= urgent_p0;
        if (vld_p0)
          r_ref_rank <= rank_p0;
      end
    end
  end

endmodule
